// File: rtl/sky130_as_sc_hs_rosc_meter.sv
// Ring-oscillator controller and edge counter: enables the hs-cell ring, waits for it to settle,
// then counts synchronised rising edges of RO_IN over a programmable window of CLK cycles.
module sky130_as_sc_hs_rosc_meter #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              CLK,
    input  logic              RESET_B,
    input  logic              START,
    input  logic [GATE_W-1:0] GATE_LEN,
    input  logic              RO_IN,
    output logic              RO_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  COUNT,
    output logic              OVF
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [GATE_W-1:0]   GATE_ONE    = GATE_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WARMUP  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [1:0]             r_state;
    logic [SETTLE_W-1:0]    r_settle_cnt;
    logic [GATE_W-1:0]      r_gate_cnt;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ovf;
    logic                   r_ro_en;
    logic                   r_busy;
    logic                   r_done;

    logic       w_synced;
    logic       w_rise;
    logic [1:0] w_state_nxt;
    logic       w_start_acc;
    logic       w_run_nxt;
    logic [CNT_W:0] w_inc;

    // Saturating increment; the top bit flags that the count was already at all-ones.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] res;
        if (&c) begin
            res = {1'b1, c};
        end else begin
            res = {1'b0, c + CNT_ONE};
        end
        return res;
    endfunction

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_synced & ~r_prev;
    assign w_inc    = sat_inc(r_count);
    assign w_run_nxt = (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_MEASURE);

    // Synchroniser chain and previous-value register for edge detection.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], RO_IN};
            r_prev <= w_synced;
        end
    end

    // Next-state logic; a START is only accepted while not busy (IDLE or DONE).
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_state_nxt = ST_WARMUP;
                    w_start_acc = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (r_settle_cnt == {SETTLE_W{1'b0}}) begin
                    if (r_gate_cnt == {GATE_W{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_MEASURE;
                    end
                end else begin
                    w_state_nxt = ST_WARMUP;
                end
            end
            ST_MEASURE: begin
                if (r_gate_cnt == GATE_ONE) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and the registered handshake outputs, which follow the next state.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state <= ST_IDLE;
            r_ro_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ro_en <= w_run_nxt;
            r_busy  <= w_run_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Settle and gate down-counters; the gate counter holds the latched window length until MEASURE.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_settle_cnt <= {SETTLE_W{1'b0}};
            r_gate_cnt   <= {GATE_W{1'b0}};
        end else if (w_start_acc) begin
            r_settle_cnt <= SETTLE_LOAD;
            r_gate_cnt   <= GATE_LEN;
        end else begin
            if ((r_state == ST_WARMUP) && (r_settle_cnt != {SETTLE_W{1'b0}})) begin
                r_settle_cnt <= r_settle_cnt - SETTLE_ONE;
            end
            if ((r_state == ST_MEASURE) && (r_gate_cnt != {GATE_W{1'b0}})) begin
                r_gate_cnt <= r_gate_cnt - GATE_ONE;
            end
        end
    end

    // Edge counter: cleared on an accepted START, saturates instead of wrapping.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_count <= {CNT_W{1'b0}};
            r_ovf   <= 1'b0;
        end else if (w_start_acc) begin
            r_count <= {CNT_W{1'b0}};
            r_ovf   <= 1'b0;
        end else if ((r_state == ST_MEASURE) && w_rise) begin
            r_count <= w_inc[CNT_W-1:0];
            r_ovf   <= r_ovf | w_inc[CNT_W];
        end
    end

    assign RO_EN = r_ro_en;
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign COUNT = r_count;
    assign OVF   = r_ovf;

endmodule

// File: tb/tb_sky130_as_sc_hs_rosc_meter.sv
// Bench for the ring-oscillator meter: directed runs checked cycle by cycle against an
// edge-counting model over the sampled RO_IN history, plus literal expectations.
module tb_sky130_as_sc_hs_rosc_meter;

    localparam int SETTLE = 8;
    localparam int SS     = 2;

    logic        CLK = 1'b0;
    logic        RESET_B = 1'b0;
    logic        START = 1'b0;
    logic [15:0] GATE_LEN = 16'd0;
    logic        RO_IN = 1'b0;

    logic        ro_en_a, busy_a, done_a, ovf_a;
    logic [15:0] count_a;
    logic        ro_en_b, busy_b, done_b, ovf_b;
    logic [3:0]  count_b;

    int n_pass = 0;
    int n_total = 0;
    int ro_period = 8;

    sky130_as_sc_hs_rosc_meter #(.CNT_W(16), .GATE_W(16), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RESET_B(RESET_B), .START(START), .GATE_LEN(GATE_LEN), .RO_IN(RO_IN),
        .RO_EN(ro_en_a), .BUSY(busy_a), .DONE(done_a), .COUNT(count_a), .OVF(ovf_a));

    sky130_as_sc_hs_rosc_meter #(.CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SS)) dut4 (
        .CLK(CLK), .RESET_B(RESET_B), .START(START), .GATE_LEN(GATE_LEN), .RO_IN(RO_IN),
        .RO_EN(ro_en_b), .BUSY(busy_b), .DONE(done_b), .COUNT(count_b), .OVF(ovf_b));

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: a run accepted at edge n with window g is busy after edges n..n+S+g-1, done after
    // edge n+S+g, and counts the 0->1 steps of RO_IN as seen through the synchroniser in the window.
    int   cyc = 0;
    logic hist [0:16383];
    int   m_n = 0;
    int   m_g = 0;
    bit   m_act = 1'b0;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_raw = 0;
    bit   m_cnt_valid = 1'b1;

    function automatic logic hv(input int i);
        if (i < 0) return 1'b0;
        return hist[i];
    endfunction

    function automatic int edges(input int n, input int g);
        int e = 0;
        for (int k = n + SETTLE + 1; k <= n + SETTLE + g; k++) begin
            if (hv(k - SS) == 1'b1 && hv(k - SS - 1) == 1'b0) e++;
        end
        return e;
    endfunction

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!RESET_B) begin
            for (int i = 0; i <= SS + 1; i++) begin
                if (cyc - i >= 0) hist[cyc - i] <= 1'b0;
            end
            m_act <= 1'b0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_raw <= 0;
            m_cnt_valid <= 1'b1;
        end else begin
            hist[cyc] <= RO_IN;
            if (START && !(m_act && cyc <= m_n + SETTLE + m_g)) begin
                m_act <= 1'b1;
                m_n <= cyc;
                m_g <= int'(GATE_LEN);
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_raw <= 0;
                m_cnt_valid <= 1'b0;
            end else if (m_act) begin
                m_busy <= (cyc <= m_n + SETTLE + m_g - 1);
                m_done <= (cyc == m_n + SETTLE + m_g);
                if (cyc == m_n + SETTLE + m_g) begin
                    m_raw <= edges(m_n, m_g);
                    m_cnt_valid <= 1'b1;
                end
            end else begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end
    end

    // Compare process: every cycle, just after the active edge.
    initial forever begin
        @(posedge CLK);
        #1;
        if (cyc > 0) begin
            chk("ro_en", ro_en_a, m_busy);
            chk("busy", busy_a, m_busy);
            chk("done", done_a, m_done);
            chk("ro_en4", ro_en_b, m_busy);
            chk("busy4", busy_b, m_busy);
            chk("done4", done_b, m_done);
            if (m_cnt_valid) begin
                chk("count", count_a, (m_raw > 65535) ? 65535 : m_raw);
                chk("ovf", ovf_a, (m_raw > 65535) ? 1 : 0);
                chk("count4", count_b, (m_raw > 15) ? 15 : m_raw);
                chk("ovf4", ovf_b, (m_raw > 15) ? 1 : 0);
            end
        end
    end

    // Free-running ring-oscillator stand-in, square wave of ro_period CLK cycles.
    initial begin
        int ph = 0;
        forever begin
            @(negedge CLK);
            ph++;
            RO_IN = ((ph % ro_period) < (ro_period / 2));
        end
    end

    task automatic do_run(input int g, output int lat, output int nbusy, output int nroen);
        START = 1'b1;
        GATE_LEN = g[15:0];
        lat = 0;
        nbusy = 0;
        nroen = 0;
        for (int j = 1; j <= 3000 && lat == 0; j++) begin
            @(negedge CLK);
            if (j == 1) START = 1'b0;
            nbusy += int'(busy_a);
            nroen += int'(ro_en_a);
            if (done_a) lat = j;
        end
        chk("run_done_seen", (lat != 0) ? 1 : 0, 1);
    endtask

    initial begin
        int lat, nb, nr, ndone;

        // Reset held with START high and RO_IN toggling.
        RESET_B = 1'b0;
        START = 1'b1;
        GATE_LEN = 16'd80;
        repeat (10) @(negedge CLK);
        chk("rst_ro_en", ro_en_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_ovf", ovf_a, 0);
        START = 1'b0;
        RESET_B = 1'b1;
        repeat (5) @(negedge CLK);

        // Period 8, window 80.
        do_run(80, lat, nb, nr);
        chk("t2_latency", lat, 89);
        chk("t2_busy_cycles", nb, 88);
        chk("t2_roen_cycles", nr, 88);
        chk("t2_count", count_a, 10);
        chk("t2_ovf", ovf_a, 0);
        repeat (3) @(negedge CLK);

        // Zero-length window.
        do_run(0, lat, nb, nr);
        chk("t3_latency", lat, 9);
        chk("t3_roen_cycles", nr, 8);
        chk("t3_count", count_a, 0);
        repeat (3) @(negedge CLK);

        // Saturation in the 4-bit instance, then a normal run clears OVF.
        ro_period = 4;
        repeat (6) @(negedge CLK);
        do_run(100, lat, nb, nr);
        chk("t4_latency", lat, 109);
        chk("t4_count4", count_b, 15);
        chk("t4_ovf4", ovf_b, 1);
        chk("t4_count16", count_a, 25);
        chk("t4_ovf16", ovf_a, 0);
        repeat (2) @(negedge CLK);
        do_run(8, lat, nb, nr);
        chk("t4b_count4", count_b, 2);
        chk("t4b_ovf4", ovf_b, 0);

        // START pulses while busy are ignored.
        ro_period = 8;
        repeat (6) @(negedge CLK);
        START = 1'b1;
        GATE_LEN = 16'd40;
        lat = 0;
        for (int j = 1; j <= 500 && lat == 0; j++) begin
            @(negedge CLK);
            START = (j == 3 || j == 20) ? 1'b1 : 1'b0;
            if (j == 3) GATE_LEN = 16'd5;
            if (j == 20) GATE_LEN = 16'd7;
            if (done_a) lat = j;
        end
        chk("t5_latency", lat, 49);
        chk("t5_count", count_a, 5);
        repeat (3) @(negedge CLK);

        // START held high through DONE: the next run starts without an idle cycle.
        START = 1'b1;
        GATE_LEN = 16'd16;
        lat = 0;
        for (int j = 1; j <= 500 && lat == 0; j++) begin
            @(negedge CLK);
            if (done_a) lat = j;
        end
        chk("t5b_latency", lat, 25);
        @(negedge CLK);
        START = 1'b0;
        chk("t5b_no_idle_busy", busy_a, 1);
        lat = 0;
        for (int j = 1; j <= 500 && lat == 0; j++) begin
            @(negedge CLK);
            if (done_a) lat = j;
        end
        chk("t5b_second_latency", lat, 24);
        chk("t5b_count", count_a, 2);
        repeat (3) @(negedge CLK);

        // Reset mid-MEASURE aborts the run.
        START = 1'b1;
        GATE_LEN = 16'd80;
        @(negedge CLK);
        START = 1'b0;
        repeat (29) @(negedge CLK);
        RESET_B = 1'b0;
        #1;
        chk("t6_async_ro_en", ro_en_a, 0);
        chk("t6_async_busy", busy_a, 0);
        chk("t6_async_count", count_a, 0);
        repeat (2) @(negedge CLK);
        RESET_B = 1'b1;
        ndone = 0;
        for (int j = 0; j < 120; j++) begin
            @(negedge CLK);
            ndone += int'(done_a);
        end
        chk("t6_no_done", ndone, 0);
        do_run(80, lat, nb, nr);
        chk("t6_latency", lat, 89);
        chk("t6_count", count_a, 10);
        chk("t6_ovf", ovf_a, 0);

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
